// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the sorter data-memory port arbiter.
package dm_port_arbiter_pkg;

   // Arbiter ownership state: free round-robin, or held by the sorter during a run.
   typedef enum logic {
      IDLE   = 1'b0,
      LOCK_A = 1'b1
   } arb_state_t;

   // Port identifiers as stored in the last-granted pointer.
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   // Width of the debug-port stall counter.
   localparam int unsigned STALL_W = 16;

endpackage

// File: rtl/dm_port_arbiter_sat_counter.sv
// Saturating up-counter; holds at all-ones until reset.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Count qualifying cycles, stopping at the maximum value.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of the single-port synchronous-read sorter memory.
// Port A is the sorting engine, port B the serial debug unit.
module dm_port_arbiter
   import dm_port_arbiter_pkg::*;
#(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 32
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               a_req,
   input  logic               a_we,
   input  logic [AW-1:0]      a_addr,
   input  logic [DW-1:0]      a_wdata,
   input  logic               a_lock,
   output logic               a_gnt,
   output logic               a_rvalid,
   output logic [DW-1:0]      a_rdata,
   input  logic               b_req,
   input  logic               b_we,
   input  logic [AW-1:0]      b_addr,
   input  logic [DW-1:0]      b_wdata,
   output logic               b_gnt,
   output logic               b_rvalid,
   output logic [DW-1:0]      b_rdata,
   output logic [AW-1:0]      mem_addr,
   output logic               mem_we,
   output logic [DW-1:0]      mem_din,
   input  logic [DW-1:0]      mem_dout,
   output logic [STALL_W-1:0] b_stall_cnt
);

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic          last;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] din_q;
   logic          b_stall_inc;

   // Grant decision and next ownership state from current state, pointer and requests.
   always_comb begin
      a_gnt     = 1'b0;
      b_gnt     = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: begin
            if (a_req && b_req) begin
               if (last == PORT_A) begin
                  b_gnt = 1'b1;
               end else begin
                  a_gnt = 1'b1;
               end
            end else begin
               a_gnt = a_req;
               b_gnt = b_req;
            end
            if (a_gnt && a_lock) begin
               state_nxt = LOCK_A;
            end
         end
         LOCK_A: begin
            // Lock release only changes ownership from the next cycle on.
            a_gnt = a_req;
            if (!a_lock) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Steer the granted port onto the memory; address and data hold when idle.
   always_comb begin
      mem_addr = addr_q;
      mem_din  = din_q;
      mem_we   = 1'b0;
      if (a_gnt) begin
         mem_addr = a_addr;
         mem_din  = a_wdata;
         mem_we   = a_we;
      end else if (b_gnt) begin
         mem_addr = b_addr;
         mem_din  = b_wdata;
         mem_we   = b_we;
      end
   end

   // Ownership state, last-granted pointer, held memory fields and read-return flags.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         last     <= PORT_B;
         addr_q   <= '0;
         din_q    <= '0;
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
      end else begin
         state    <= state_nxt;
         addr_q   <= mem_addr;
         din_q    <= mem_din;
         a_rvalid <= a_gnt && !a_we;
         b_rvalid <= b_gnt && !b_we;
         if (a_gnt) begin
            last <= PORT_A;
         end else if (b_gnt) begin
            last <= PORT_B;
         end
      end
   end

   // Read data is only driven while the matching valid is high.
   always_comb begin
      a_rdata = a_rvalid ? mem_dout : '0;
      b_rdata = b_rvalid ? mem_dout : '0;
   end

   assign b_stall_inc = b_req && !b_gnt;

   sat_counter #(
      .WIDTH(STALL_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (b_stall_inc),
      .count (b_stall_cnt)
   );

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Shares the single-port sorter data memory between two requesters: port A, the sorting engine, and port B, the serial debug unit. B issues its accesses on `clk_ld`-driven debug traffic. The arbiter grants one access per cycle, with round-robin fairness and a lock mode that gives the sorter exclusive ownership during a run. It returns read data with fixed one-cycle latency and counts cycles B spent stalled, for the debug cycle report. It sits between both requesters and the synchronous-read data memory in the sort test top.

## Interface
- AW, 8, word-address width
- DW, 32, data width

- clk  in  1  system clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- a_req  in  1  sorter access request
- a_we  in  1  sorter write enable (qualifies a_req)
- a_addr  in  AW  sorter word address
- a_wdata  in  DW  sorter write data
- a_lock  in  1  sorter run in progress; holds ownership at A
- a_gnt  out  1  A access accepted this cycle
- a_rvalid  out  1  A read data valid
- a_rdata  out  DW  A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same roles for debug port B
- mem_addr  out  AW  memory address
- mem_we  out  1  memory write strobe
- mem_din  out  DW  memory write data
- mem_dout  in  DW  memory read data, valid 1 cycle after address
- b_stall_cnt  out  16  cycles with b_req high and b_gnt low, saturating

## Operation
- State register: IDLE, LOCK_A. Pointer `last` (0=A, 1=B) records the last granted port.
- IDLE: only one port requesting -> that port is granted. Both requesting -> grant the port not equal to `last`. A granted while a_lock=1 -> next state LOCK_A.
- LOCK_A: only A may be granted; b_gnt=0 regardless of b_req. a_lock=0 -> IDLE next cycle. The grant rule is evaluated with the current state, so B may win in that same next cycle.
- Grants are combinational from the state, `last` and the requests. At most one grant per cycle. The mem_* outputs mux the granted port's addr/we/wdata. With no grant: mem_we=0 and mem_addr holds its last value.
- A request must stay asserted, with its fields stable, until granted. A granted write completes at that edge.
- Read return:
  - Granted read (we=0) -> that port's rvalid is 1 in the following cycle only.
  - rdata = mem_dout while rvalid=1, else 0.
  - rvalid is never asserted for writes.
- b_stall_cnt increments on every cycle with b_req=1 and b_gnt=0. It saturates at 16'hFFFF and is cleared only by reset.

## Timing
- Reset values: state=IDLE, last=1 (A wins the first contention), a_rvalid=b_rvalid=0, rdata=0, b_stall_cnt=0, mem_addr=0, mem_we=0, mem_din=0.
- Grant latency is 0 cycles (same cycle as req when eligible). Read latency is 1 cycle.
- Back-to-back:
  - A requester may be granted on consecutive cycles when it is alone.
  - Under sustained dual contention, grants alternate A, B, A, B.
- a_lock rising while B already owns a granted read: the B read still returns rvalid next cycle, and the lock takes effect from the next A grant.
- Reset asserted mid-operation: everything returns to reset values asynchronously. A pending rvalid is discarded and not replayed.

## Structure
- A shared package holds the state encoding (IDLE, LOCK_A), the port-id constants PORT_A=0 and PORT_B=1, and the stall-counter width 16.
- The saturating stall counter is a natural sub-module, `sat_counter` (parameterised width, inc, output).

## Test plan
- Reset, then idle: all outputs 0, and b_stall_cnt=0 after 10 cycles.
- A writes 32'hDEADBEEF to addr 3, then B reads addr 3. Required: a_gnt at the write cycle, b_gnt next cycle, b_rvalid=1 and b_rdata=32'hDEADBEEF one cycle later, a_rvalid never asserted.
- Both ports hold continuous reads for 6 cycles from reset. Required: grants A, B, A, B, A, B, and b_stall_cnt=3.
- a_lock=1 with a_req and b_req high for 5 cycles. Required: A granted 5 times, b_gnt=0 throughout, b_stall_cnt=5. After a_lock drops (a_req still high), B is granted in the following cycle.
- A read is granted, then rstn is pulsed low before the return cycle. Required: a_rvalid stays 0, state is IDLE, and the next contention is won by A.
- Force b_stall_cnt to 16'hFFFE by holding B blocked under lock. Required: it reaches 16'hFFFF and stays there for 3 more blocked cycles.
